// File: rtl/spfifo_pkg.sv
// Shared types and helpers for the single-port-RAM FIFO controller.
package spfifo_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } gnt_e;

    // Occupancy counts RAM + in-flight read + 2 buffered words, so it reaches DEPTH+2.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 2;
    endfunction

endpackage

// File: rtl/spfifo_if.sv
// Push/pop handshake and RAM port bundle between the FIFO controller and its environment.
interface spfifo_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
);
    import spfifo_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = occ_width(DEPTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
    logic             mem_wen;
    logic             mem_ren;
    logic [AW-1:0]    mem_waddr;
    logic [AW-1:0]    mem_raddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  in_valid, in_data, out_ready, mem_rdata,
        output in_ready, out_valid, out_data, count,
               mem_wen, mem_ren, mem_waddr, mem_raddr, mem_wdata
    );

    modport master (
        output in_valid, in_data, out_ready, mem_rdata,
        input  in_ready, out_valid, out_data, count,
               mem_wen, mem_ren, mem_waddr, mem_raddr, mem_wdata
    );

endinterface

// File: rtl/spfifo_obuf.sv
// Two-entry output buffer that absorbs RAM read latency; entry 0 is always the head.
module spfifo_obuf #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       cnt,
    output logic             valid,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] ent0_q, ent0_d;
    logic [WIDTH-1:0] ent1_q, ent1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             valid_q, valid_d;

    // Next-state of the buffer entries; a push never arrives while full without a pop.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    ent0_d = push_data;
                end else begin
                    ent1_d = push_data;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    ent0_d = push_data;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = push_data;
                end
            end
            default: begin
            end
        endcase
        valid_d = (cnt_d != 2'd0);
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q  <= {WIDTH{1'b0}};
            ent1_q  <= {WIDTH{1'b0}};
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign cnt   = cnt_q;
    assign valid = valid_q;
    assign head  = ent0_q;

endmodule

// File: rtl/spfifo_ctrl.sv
// FIFO controller sharing one single-port RAM between pushes and reads,
// with round-robin arbitration on contention and a 2-entry output buffer.
module spfifo_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    spfifo_if.slave  bus
);
    import spfifo_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = occ_width(DEPTH);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] ram_cnt_q, ram_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_inflight_q, rd_inflight_d;
    logic          last_gnt_q, last_gnt_d;

    logic [1:0]       ob_cnt_s;
    logic             ob_valid_s;
    logic [WIDTH-1:0] ob_head_s;
    logic [2:0]       ob_load_s;
    logic             pop_now_s;
    logic             not_full_s;
    logic             wr_want_s;
    logic             rd_want_s;
    logic             in_ready_s;
    gnt_e             gnt_s;

    // Arbitration and next-state; ob_load_s is the buffer occupancy after this edge.
    always_comb begin
        pop_now_s  = ob_valid_s && bus.out_ready;
        ob_load_s  = {1'b0, ob_cnt_s} + {2'b00, rd_inflight_q} - {2'b00, pop_now_s};
        not_full_s = (ram_cnt_q < FULL_LVL);
        wr_want_s  = bus.in_valid && not_full_s;
        rd_want_s  = rst_n && (ram_cnt_q != {CW{1'b0}}) && (ob_load_s < 3'd2);
        in_ready_s = rst_n && not_full_s && !(rd_want_s && last_gnt_q);

        if (wr_want_s && in_ready_s) begin
            gnt_s = GNT_WR;
        end else if (rd_want_s) begin
            gnt_s = GNT_RD;
        end else begin
            gnt_s = GNT_NONE;
        end

        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        ram_cnt_d = ram_cnt_q;
        case (gnt_s)
            GNT_WR: begin
                wptr_d    = wptr_q + PTR_ONE;
                ram_cnt_d = ram_cnt_q + CNT_ONE;
            end
            GNT_RD: begin
                rptr_d    = rptr_q + PTR_ONE;
                ram_cnt_d = ram_cnt_q - CNT_ONE;
            end
            default: begin
            end
        endcase

        if (wr_want_s && rd_want_s) begin
            last_gnt_d = (gnt_s == GNT_WR);
        end else begin
            last_gnt_d = last_gnt_q;
        end

        rd_inflight_d = (gnt_s == GNT_RD);
        count_d       = ram_cnt_d + CW'(rd_inflight_d) + CW'(ob_load_s);
    end

    // Controller state; last_gnt resets to 1 so the first contention goes to the read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q        <= {AW{1'b0}};
            rptr_q        <= {AW{1'b0}};
            ram_cnt_q     <= {CW{1'b0}};
            count_q       <= {CW{1'b0}};
            rd_inflight_q <= 1'b0;
            last_gnt_q    <= 1'b1;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            ram_cnt_q     <= ram_cnt_d;
            count_q       <= count_d;
            rd_inflight_q <= rd_inflight_d;
            last_gnt_q    <= last_gnt_d;
        end
    end

    spfifo_obuf #(.WIDTH(WIDTH)) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_inflight_q),
        .push_data (bus.mem_rdata),
        .pop       (pop_now_s),
        .cnt       (ob_cnt_s),
        .valid     (ob_valid_s),
        .head      (ob_head_s)
    );

    assign bus.in_ready  = in_ready_s;
    assign bus.mem_wen   = (gnt_s == GNT_WR);
    assign bus.mem_ren   = (gnt_s == GNT_RD);
    assign bus.mem_waddr = wptr_q;
    assign bus.mem_raddr = rptr_q;
    assign bus.mem_wdata = bus.in_data;
    assign bus.out_valid = ob_valid_s;
    assign bus.out_data  = ob_head_s;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_spfifo_ctrl.sv
// Self-checking bench for spfifo_ctrl with a flop-RAM model and a queue-based reference.
module tb_spfifo_ctrl;
    import spfifo_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 32;
    localparam int CW    = occ_width(DEPTH);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spfifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    spfifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Single-port RAM: 1-cycle write, 1-cycle registered read.
    logic [WIDTH-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_wen) ram[bus.mem_waddr] <= bus.mem_wdata;
        if (bus.mem_ren) bus.mem_rdata <= ram[bus.mem_raddr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h0000;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_count",     32'(bus.count),     32'd0);
        chk("rst_mem_en",    32'({bus.mem_wen, bus.mem_ren}), 32'd0);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
    endtask

    typedef struct {
        logic             iv;
        logic [WIDTH-1:0] id;
        logic             ordy;
        logic             e_irdy;
        logic             e_ov;
        logic             chk_od;
        logic [WIDTH-1:0] e_od;
        logic [CW-1:0]    e_cnt;
        logic             e_wen;
        logic             e_ren;
    } vec_t;

    vec_t tbl [5];

    logic [WIDTH-1:0] q [$];
    int k;
    int exp_w;
    int pops;
    int popped;
    logic prev_wen;

    initial begin
        // Single push of 0xA5A5 from an empty FIFO, consumer always ready.
        tbl[0] = '{iv:1'b1, id:16'hA5A5, ordy:1'b1, e_irdy:1'b1, e_ov:1'b0, chk_od:1'b0, e_od:16'h0000, e_cnt:7'd0, e_wen:1'b1, e_ren:1'b0};
        tbl[1] = '{iv:1'b0, id:16'h0000, ordy:1'b1, e_irdy:1'b0, e_ov:1'b0, chk_od:1'b0, e_od:16'h0000, e_cnt:7'd1, e_wen:1'b0, e_ren:1'b1};
        tbl[2] = '{iv:1'b0, id:16'h0000, ordy:1'b1, e_irdy:1'b1, e_ov:1'b0, chk_od:1'b0, e_od:16'h0000, e_cnt:7'd1, e_wen:1'b0, e_ren:1'b0};
        tbl[3] = '{iv:1'b0, id:16'h0000, ordy:1'b1, e_irdy:1'b1, e_ov:1'b1, chk_od:1'b1, e_od:16'hA5A5, e_cnt:7'd1, e_wen:1'b0, e_ren:1'b0};
        tbl[4] = '{iv:1'b0, id:16'h0000, ordy:1'b1, e_irdy:1'b1, e_ov:1'b0, chk_od:1'b0, e_od:16'h0000, e_cnt:7'd0, e_wen:1'b0, e_ren:1'b0};

        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid  = tbl[i].iv;
            bus.in_data   = tbl[i].id;
            bus.out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", i),  32'(bus.in_ready),  32'(tbl[i].e_irdy));
            chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("vec%0d_count", i),     32'(bus.count),     32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_mem_wen", i),   32'(bus.mem_wen),   32'(tbl[i].e_wen));
            chk($sformatf("vec%0d_mem_ren", i),   32'(bus.mem_ren),   32'(tbl[i].e_ren));
            if (tbl[i].chk_od) chk($sformatf("vec%0d_out_data", i), 32'(bus.out_data), 32'(tbl[i].e_od));
            @(negedge clk);
        end

        // Fill with consumer stalled: RAM plus both buffer slots hold 34 words.
        do_reset();
        k = 0;
        for (int c = 0; c < 150; c++) begin
            bus.in_valid = (k < 41);
            bus.in_data  = 16'(k);
            #1;
            if (bus.in_valid && bus.in_ready) k++;
            @(negedge clk);
        end
        #1;
        chk("full_accepted",  32'(k),             32'd34);
        chk("full_in_ready",  32'(bus.in_ready),  32'd0);
        chk("full_count",     32'(bus.count),     32'd34);
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        exp_w = 0;
        for (int c = 0; c < 120; c++) begin
            #1;
            if (bus.out_valid) begin
                chk("drain_data", 32'(bus.out_data), 32'(exp_w));
                exp_w++;
            end
            @(negedge clk);
        end
        #1;
        chk("drain_words", 32'(exp_w),     32'd34);
        chk("drain_count", 32'(bus.count), 32'd0);
        @(negedge clk);

        // Both sides continuously active: grants alternate, one word out per two cycles.
        do_reset();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            bus.in_data = 16'(k);
            #1;
            if (bus.in_ready) k++;
            @(negedge clk);
        end
        #1;
        prev_wen = bus.mem_wen;
        pops = 0;
        @(negedge clk);
        for (int c = 0; c < 40; c++) begin
            bus.in_data = 16'(k);
            #1;
            chk("alt_wen_toggles", 32'(bus.mem_wen), 32'(!prev_wen));
            chk("alt_ren_opposite", 32'(bus.mem_ren), 32'(prev_wen));
            prev_wen = bus.mem_wen;
            if (bus.in_ready) k++;
            if (bus.out_valid) pops++;
            @(negedge clk);
        end
        chk("alt_pop_rate", 32'(pops), 32'd20);

        // Random stalls over 200 words against a queue reference.
        do_reset();
        q.delete();
        k = 0;
        popped = 0;
        for (int c = 0; c < 6000 && popped < 200; c++) begin
            bus.in_valid  = (k < 200) && ($urandom_range(9) < 7);
            bus.in_data   = 16'($urandom);
            bus.out_ready = ($urandom_range(9) < 6);
            #1;
            chk("rnd_count", 32'(bus.count), 32'(q.size()));
            chk("rnd_one_port", 32'(bus.mem_wen && bus.mem_ren), 32'd0);
            chk("rnd_wen_hs", 32'(bus.mem_wen), 32'(bus.in_valid && bus.in_ready));
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    chk("rnd_data", 32'(bus.out_data), 32'(q[0]));
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        popped++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(bus.in_data);
                k++;
            end
            @(negedge clk);
        end
        chk("rnd_all_popped", 32'(popped), 32'd200);

        // Reset while holding 10 words with a read in flight.
        do_reset();
        bus.out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 60; c++) begin
            bus.in_valid = (k < 11);
            bus.in_data  = 16'(16'h0100 + k);
            #1;
            if (bus.in_valid && bus.in_ready) k++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #1;
        chk("mid_pre_count", 32'(bus.count), 32'd11);
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk("mid_read_issued", 32'(bus.mem_ren), 32'd1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        chk("mid_count10", 32'(bus.count), 32'd10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_count",     32'(bus.count),     32'd0);
        chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h1234;
        bus.out_ready = 1'b1;
        #1;
        chk("post_push_accept", 32'(bus.mem_wen), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int c = 1; c < 3; c++) begin
            #1;
            chk($sformatf("post_cycle%0d_no_valid", c), 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        #1;
        chk("post_out_valid", 32'(bus.out_valid), 32'd1);
        chk("post_out_data",  32'(bus.out_data),  32'h1234);
        @(negedge clk);
        #1;
        chk("post_empty_count", 32'(bus.count),     32'd0);
        chk("post_empty_valid", 32'(bus.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
